// File: rtl/fetch_stage64_pkg.sv
// Shared encodings for the RV64 instruction-fetch stage.
package fetch_stage64_pkg;

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        PcSeq      = 2'b00,
        PcHold     = 2'b01,
        PcRedirect = 2'b10,
        PcHoldAlt  = 2'b11
    } next_pc_sel_e;

    function automatic logic sel_allows_issue(input next_pc_sel_e sel);
        return sel == PcSeq;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush; DEPTH must be a power of 2.
module fetch_fifo #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head_data,
    output logic [CNT_BITS-1:0] count
);

    localparam int unsigned PtrBits = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PtrBits-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrBits-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    // Push is accepted at full only when the head leaves in the same cycle.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_BITS'(DEPTH)) || pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrBits'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrBits'(1);
            end
            count_d = count_q + CNT_BITS'(push_ok) - CNT_BITS'(pop_ok);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_stage64.sv
// Instruction-fetch stage: owns the PC, issues in-order word requests and buffers
// returned instructions with their PCs for decode.
module fetch_stage64
    import fetch_stage64_pkg::*;
#(
    parameter int unsigned             CORE         = 0,
    parameter int unsigned             ADDRESS_BITS = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
    parameter int unsigned             FETCH_DEPTH  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              next_PC_sel,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    i_mem_read,
    output logic                    i_mem_hazard,
    output logic                    i_mem_req_valid,
    output logic [ADDRESS_BITS-1:0] i_mem_req_addr,
    input  logic                    i_mem_req_ready,
    input  logic                    i_mem_rsp_valid,
    input  logic [31:0]             i_mem_rsp_data,
    input  logic                    decode_ready,
    output logic                    inst_valid_decode,
    output logic [31:0]             instruction_decode,
    output logic [ADDRESS_BITS-1:0] pc_decode
);

    localparam int unsigned CntBits  = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned SumBits  = CntBits + 1;
    localparam int unsigned BufWidth = ADDRESS_BITS + 32;

    next_pc_sel_e            pc_sel;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic [CntBits-1:0]      outstanding_q, outstanding_d;
    logic [CntBits-1:0]      drop_q, drop_d;
    logic [CntBits-1:0]      pcq_count, buf_count;
    logic [ADDRESS_BITS-1:0] pcq_head;
    logic [BufWidth-1:0]     buf_head, buf_push_data;
    logic [SumBits-1:0]      in_use;
    logic                    has_space, accept, rsp_drop;
    logic                    buf_push, buf_pop, buf_empty;

    assign pc_sel   = next_pc_sel_e'(next_PC_sel);
    assign redirect = (pc_sel == PcRedirect);

    // Issue side: in-flight plus buffered entries never exceed FETCH_DEPTH.
    always_comb begin
        in_use          = SumBits'(outstanding_q) + SumBits'(buf_count);
        has_space       = in_use < SumBits'(FETCH_DEPTH);
        i_mem_req_valid = !reset && i_mem_read && sel_allows_issue(pc_sel) && has_space;
        i_mem_req_addr  = pc_q;
        accept          = i_mem_req_valid && i_mem_req_ready;
    end

    // Response side: responses for requests issued before a redirect are discarded.
    always_comb begin
        rsp_drop      = i_mem_rsp_valid && (drop_q != '0);
        buf_push      = i_mem_rsp_valid && !rsp_drop && !redirect;
        buf_push_data = {pcq_head, i_mem_rsp_data};
        buf_empty     = (buf_count == '0);
        buf_pop       = !buf_empty && decode_ready;
    end

    always_comb begin
        inst_valid_decode  = !buf_empty;
        instruction_decode = buf_empty ? NopInstr : buf_head[31:0];
        pc_decode          = buf_empty ? pc_q : buf_head[BufWidth-1:32];
        i_mem_hazard       = ((outstanding_q != '0) || i_mem_req_valid) && buf_empty;
    end

    always_comb begin
        pc_d          = pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CntBits'(accept) - CntBits'(i_mem_rsp_valid);
        if (redirect) begin
            pc_d   = {target_PC[ADDRESS_BITS-1:2], 2'b00};
            drop_d = outstanding_q - CntBits'(i_mem_rsp_valid);
        end else begin
            if (accept) begin
                pc_d = pc_q + ADDRESS_BITS'(4);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CntBits'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // PCs of every accepted request, popped by each response whether kept or dropped.
    fetch_fifo #(
        .WIDTH    (ADDRESS_BITS),
        .DEPTH    (FETCH_DEPTH),
        .CNT_BITS (CntBits)
    ) u_pc_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc_q),
        .pop       (i_mem_rsp_valid),
        .head_data (pcq_head),
        .count     (pcq_count)
    );

    fetch_fifo #(
        .WIDTH    (BufWidth),
        .DEPTH    (FETCH_DEPTH),
        .CNT_BITS (CntBits)
    ) u_inst_buffer (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .head_data (buf_head),
        .count     (buf_count)
    );

    rsp_needs_outstanding: assert property (
        @(posedge clock) disable iff (reset) i_mem_rsp_valid |-> (outstanding_q != '0)
    ) else $error("fetch_stage64[%0d]: response with nothing outstanding", CORE);

    pcq_tracks_outstanding: assert property (
        @(posedge clock) disable iff (reset) pcq_count == outstanding_q
    );

endmodule
